// File: rtl/sm_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package sm_fetch_pkg;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned PC_STEP    = 4;

   // One prefetched instruction together with the address it was fetched from
   typedef struct packed {
      logic [DEF_ADDR_W-1:0] pc;
      logic [DEF_DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/sm_fetch_fifo.sv
// Prefetch FIFO of fetch entries; flush empties it in one cycle, reset also
// loads every slot with RESET_ENTRY so the head reads a known value.
module sm_fetch_fifo
   import sm_fetch_pkg::*;
#(
   parameter int unsigned  DEPTH       = 4,
   parameter fetch_entry_t RESET_ENTRY = '0
) (
   input  logic                         clk,
   input  logic                         rst_p,
   input  logic                         push,
   input  fetch_entry_t                 push_data,
   input  logic                         pop,
   input  logic                         flush,
   output fetch_entry_t                 head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !flush;
   assign do_pop  = pop && !flush && (count != '0);

   assign head  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // Storage, pointers and occupancy; flush wins over push and pop
   always_ff @(posedge clk) begin
      if (rst_p) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= RESET_ENTRY;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/sm_fetch_unit.sv
// Pipelined instruction fetch: credit-limited requests to a variable-latency
// memory, in-order responses buffered with their PC, redirect flush/restart.
module sm_fetch_unit
   import sm_fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = DEF_ADDR_W,
   parameter int unsigned       DATA_W   = DEF_DATA_W,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_p,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [DATA_W-1:0] imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_pc,
   output logic [ADDR_W-1:0] instr_pc_plus4,
   output logic [ADDR_W-1:0] instr_pc_plus8
);

   localparam int unsigned  CNT_W = $clog2(DEPTH+1);
   localparam int unsigned  SUM_W = CNT_W + 2;
   localparam fetch_entry_t RESET_ENTRY = '{pc: DEF_ADDR_W'(RESET_PC), instr: '0};

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] rsp_pc;
   logic [CNT_W-1:0]  occ;
   logic [CNT_W-1:0]  inflight;
   logic [CNT_W-1:0]  drop;
   logic [SUM_W-1:0]  outstanding;
   logic [ADDR_W-1:0] redirect_base;
   logic              redirect_lsb_unused;
   logic              credit;
   logic              req_fire;
   logic              rsp_kept;
   logic              rsp_drop;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   fetch_entry_t      push_entry;
   fetch_entry_t      head_entry;

   // Every slot is reserved for a buffered, live or to-be-discarded word
   assign outstanding = SUM_W'(occ) + SUM_W'(inflight) + SUM_W'(drop);
   assign credit      = outstanding < SUM_W'(DEPTH);

   assign redirect_base       = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign redirect_lsb_unused = ^redirect_pc[1:0];

   assign imem_req_valid = credit && !redirect_valid && !rst_p;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response in the redirect cycle belongs to the old stream
   assign rsp_kept = imem_rsp_valid && (drop == '0) && !redirect_valid;
   assign rsp_drop = imem_rsp_valid && (drop != '0);
   assign fifo_pop = instr_valid && instr_ready && !redirect_valid;

   assign push_entry = '{pc: DEF_ADDR_W'(rsp_pc), instr: DEF_DATA_W'(imem_rsp_data)};

   // Fetch/response PCs and the live/discard request counters
   always_ff @(posedge clk) begin
      if (rst_p) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_base;
         rsp_pc   <= redirect_base;
         inflight <= '0;
         drop     <= drop + inflight - CNT_W'(imem_rsp_valid);
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
         end
         if (rsp_kept) begin
            rsp_pc <= rsp_pc + ADDR_W'(PC_STEP);
         end
         inflight <= inflight + CNT_W'(req_fire) - CNT_W'(rsp_kept);
         if (rsp_drop) begin
            drop <= drop - CNT_W'(1);
         end
      end
   end

   sm_fetch_fifo #(
      .DEPTH       (DEPTH),
      .RESET_ENTRY (RESET_ENTRY)
   ) u_fifo (
      .clk       (clk),
      .rst_p     (rst_p),
      .push      (rsp_kept),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .flush     (redirect_valid),
      .head      (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (occ)
   );

   assign instr_valid    = !fifo_empty;
   assign instr_data     = DATA_W'(head_entry.instr);
   assign instr_pc       = ADDR_W'(head_entry.pc);
   assign instr_pc_plus4 = instr_pc + ADDR_W'(PC_STEP);
   assign instr_pc_plus8 = instr_pc + ADDR_W'(2 * PC_STEP);

   // Credit accounting must never let a response find the FIFO full
   a_no_overflow: assert property (@(posedge clk) disable iff (rst_p) !(rsp_kept && fifo_full));

endmodule

// File: tb/tb_sm_fetch_unit.sv
// Directed bench for sm_fetch_unit with a latency-configurable memory model
// and a scoreboard of expected {pc, data} beats checked by a separate monitor.
module tb_sm_fetch_unit;

   typedef struct {
      int          due;
      logic [31:0] addr;
   } mem_req_t;

   logic        clk = 1'b0;
   logic        rst_p = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus4;
   logic [31:0] instr_pc_plus8;

   int          cyc = 0;
   int          lat = 1;
   int          r0 = 0;
   int          checks = 0;
   int          errors = 0;
   mem_req_t    mem_q[$];
   logic [31:0] req_log[$];
   logic [31:0] pop_cyc_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] mon_pc;

   sm_fetch_unit #(.DEPTH(4)) dut (
      .clk            (clk),
      .rst_p          (rst_p),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .instr_pc_plus4 (instr_pc_plus4),
      .instr_pc_plus8 (instr_pc_plus8)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] data_of(input logic [31:0] addr);
      return addr ^ 32'hC0DE_5A5A;
   endfunction

   function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hDEAD_BEEF;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Memory: record accepted requests mid-cycle; reset discards everything pending
   always @(negedge clk) begin
      if (rst_p) begin
         mem_q.delete();
      end else if (imem_req_valid && imem_req_ready) begin
         mem_q.push_back('{due: cyc + lat, addr: imem_req_addr});
         req_log.push_back(imem_req_addr);
      end
   end

   // Memory: present each response in its due cycle, in request order
   always @(posedge clk) begin
      #1;
      if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = data_of(mem_q[0].addr);
         void'(mem_q.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
   end

   // Monitor: every consumed beat is compared against the scoreboard
   always @(negedge clk) begin
      if (!rst_p && !redirect_valid && instr_valid && instr_ready) begin
         pop_cyc_q.push_back(32'(cyc));
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got pc %h with nothing expected (cycle %0d)", instr_pc, cyc);
         end else begin
            mon_pc = exp_q.pop_front();
            chk("beat_pc", instr_pc, mon_pc);
            chk("beat_data", instr_data, data_of(mon_pc));
            chk("beat_pc_plus4", instr_pc_plus4, mon_pc + 32'd4);
            chk("beat_pc_plus8", instr_pc_plus8, mon_pc + 32'd8);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_seq(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
   endtask

   // Wait (bounded) until all expected beats were consumed, then stall decode
   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         step(1);
         n++;
      end
      chk({name, "_drained_left"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      instr_ready = 1'b0;
   endtask

   // Hold reset for two cycles, set memory latency, release at cycle r0
   task automatic do_reset(input int lat_v);
      rst_p          = 1'b1;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      step(2);
      lat   = lat_v;
      req_log.delete();
      rst_p = 1'b0;
      r0    = cyc;
   endtask

   initial begin
      // Reset values
      step(2);
      @(negedge clk);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr_data", instr_data, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_pc_plus4", instr_pc_plus4, 32'h4);
      chk("rst_pc_plus8", instr_pc_plus8, 32'h8);

      // A: streaming after reset, one instruction per cycle
      @(posedge clk);
      #1;
      expect_seq(32'h0, 4);
      pop_cyc_q.delete();
      req_log.delete();
      rst_p       = 1'b0;
      instr_ready = 1'b1;
      r0          = cyc;
      drain("a");
      for (int i = 0; i < 4; i++) chk("a_pop_cycle", qget(pop_cyc_q, i), 32'(r0 + 2 + i));
      chk("a_first_req", qget(req_log, 0), 32'h0);

      // B: decode stall limits outstanding fetches to DEPTH
      do_reset(1);
      step(9);
      chk("b_req_count", 32'(req_log.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("b_req_addr", qget(req_log, i), 32'(4 * i));
      @(negedge clk);
      chk("b_req_valid_low", 32'(imem_req_valid), 32'd0);
      chk("b_instr_valid", 32'(instr_valid), 32'd1);
      step(1);
      expect_seq(32'h0, 6);
      instr_ready = 1'b1;
      drain("b");

      // C: redirect with three requests in flight, latency 3
      do_reset(3);
      step(3);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      @(negedge clk);
      chk("c_req_blocked", 32'(imem_req_valid), 32'd0);
      step(1);
      redirect_valid = 1'b0;
      chk("c_old_req_count", 32'(req_log.size()), 32'd3);
      @(negedge clk);
      chk("c_req_valid", 32'(imem_req_valid), 32'd1);
      chk("c_req_addr", imem_req_addr, 32'h0000_0100);
      chk("c_instr_valid", 32'(instr_valid), 32'd0);
      step(1);
      expect_seq(32'h100, 3);
      instr_ready = 1'b1;
      drain("c");

      // D: redirect coinciding with a response and a pop
      do_reset(1);
      expect_seq(32'h0, 2);
      expect_seq(32'h200, 3);
      instr_ready = 1'b1;
      step(4);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      step(1);
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("d_instr_valid", 32'(instr_valid), 32'd0);
      chk("d_req_addr", imem_req_addr, 32'h0000_0200);
      drain("d");

      // E: address wrap-around
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      req_log.delete();
      step(1);
      redirect_valid = 1'b0;
      exp_q.push_back(32'hFFFF_FFF8);
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0000_0000);
      instr_ready = 1'b1;
      drain("e");
      chk("e_req0", qget(req_log, 0), 32'hFFFF_FFF8);
      chk("e_req1", qget(req_log, 1), 32'hFFFF_FFFC);
      chk("e_req2", qget(req_log, 2), 32'h0000_0000);

      // F: reset while two words are buffered and two are in flight
      do_reset(2);
      step(4);
      rst_p = 1'b1;
      @(negedge clk);
      chk("f_req_valid_rst", 32'(imem_req_valid), 32'd0);
      step(1);
      rst_p = 1'b0;
      @(negedge clk);
      chk("f_instr_valid", 32'(instr_valid), 32'd0);
      chk("f_instr_data", instr_data, 32'h0);
      chk("f_instr_pc", instr_pc, 32'h0);
      chk("f_pc_plus4", instr_pc_plus4, 32'h4);
      chk("f_pc_plus8", instr_pc_plus8, 32'h8);
      chk("f_req_valid", 32'(imem_req_valid), 32'd1);
      chk("f_req_addr", imem_req_addr, 32'h0);
      step(1);
      expect_seq(32'h0, 3);
      instr_ready = 1'b1;
      drain("f");

      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sm_fetch_unit.md
# sm_fetch_unit

Parametrised instruction-fetch front end that replaces the single-register next-PC path of the single-cycle core. It issues in-order, pipelined requests to a variable-latency instruction memory and buffers returned words with their PC in a prefetch FIFO. It presents them to decode through a valid/ready handshake, with PC+4/PC+8 precomputed for r15 reads. A redirect (taken branch or PC write) flushes buffered and in-flight fetches and restarts at a new address.

## Interface
- ADDR_W, 32, fetch address width
- DATA_W, 32, instruction width
- DEPTH, 4, prefetch FIFO entries and maximum outstanding requests; power of 2, at least 2
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock; single clock domain
- rst_p  in  1  reset; synchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; in request order; no backpressure
- imem_rsp_data  in  DATA_W  instruction word
- redirect_valid  in  1  restart fetch stream
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored and forced to 0
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decode consumes head
- instr_data  out  DATA_W  instruction at head
- instr_pc  out  ADDR_W  address of head instruction
- instr_pc_plus4  out  ADDR_W  instr_pc + 4
- instr_pc_plus8  out  ADDR_W  instr_pc + 8 (r15 value)

## Operation
- State: fetch_pc, FIFO (occupancy occ), live count inflight, discard count drop. Counter width $clog2(DEPTH+1).
- Credit: a request may be issued when occ + inflight + drop < DEPTH.
- imem_req_valid = credit && !redirect_valid && !rst_p. imem_req_addr = fetch_pc.
- Request accept (valid && ready): fetch_pc += 4, modulo 2^ADDR_W. Wrap from all-ones-minus-3 to 0 is silent. inflight += 1.
- Response with drop > 0: word discarded, drop -= 1.
- Response with drop == 0: {pc, data} pushed into FIFO, inflight -= 1. The PC comes from an internal rsp_pc register that starts at the stream base and steps by 4 per pushed word.
- Pop (instr_valid && instr_ready): head removed.
- Push and pop in the same cycle are both applied; occ is unchanged.
- Redirect cycle:
  - FIFO cleared.
  - drop <= drop + inflight. A response arriving in the same cycle is counted as old and discarded, so drop = drop + inflight − rsp_valid.
  - inflight <= 0.
  - fetch_pc and rsp_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - Any pop in that cycle is void.
  - No request is issued.
- Redirect has priority over push, pop, and issue. Back-to-back redirects each restart the stream; the last one wins.
- The FIFO never overflows: credit reserves a slot for every outstanding request. A push when full is an assertion failure.
- instr_* outputs are driven directly from the FIFO head (registered storage). Contents are undefined while instr_valid = 0.

## Timing
- Reset values:
  - imem_req_valid = 0, instr_valid = 0.
  - occ = inflight = drop = 0.
  - fetch_pc = rsp_pc = RESET_PC.
  - instr_data = 0, instr_pc = RESET_PC, instr_pc_plus4 = RESET_PC+4, instr_pc_plus8 = RESET_PC+8.
- Reset asserted mid-operation clears all state in that cycle. Responses to pre-reset requests must not be delivered by memory. Memory is reset by the same rst_p.
- The first request is offered in the first cycle with rst_p low.
- Response accepted in cycle N: instr_valid is high in cycle N+1.
- Redirect in cycle N: the first new request is offered in cycle N+1. instr_valid is 0 in N+1.
- Memory with 1-cycle latency, always ready, DEPTH ≥ 2, decode always ready: one instruction delivered per cycle in steady state.

## Structure
- Package sm_fetch_pkg holds:
  - typedef fetch_entry_t {logic [ADDR_W-1:0] pc; logic [DATA_W-1:0] instr;}, using package-level default widths.
  - constant PC_STEP = 4.
- One sub-module, sm_fetch_fifo: a synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty, and count, parametrised by DEPTH.
- Counters, credit, and redirect logic live in sm_fetch_unit.

## Test plan
- Reset then run: memory 1-cycle latency, ready=1, decode ready=1. Required: instr_pc = 0, 4, 8, 12 on consecutive cycles; instr_pc_plus8 = 8, 12, 16, 20.
- Decode stall: instr_ready=0 for 10 cycles. Required: exactly DEPTH=4 requests issued (0x0–0xC), imem_req_valid then low. After release, the order 0x0, 0x4, 0x8, 0xC is preserved with no loss.
- Redirect with 3 in flight: memory latency 3, redirect_pc=0x103. Required:
  - the 3 old responses are dropped;
  - the next request address is 0x100;
  - the first delivered instr_pc is 0x100.
- Redirect coinciding with response and pop: the same-cycle response is discarded, the pop is void, and instr_valid=0 the next cycle.
- Wrap-around: redirect_pc=0xFFFF_FFF8. Required: requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; instr_pc_plus8 at 0xFFFF_FFFC is 0x4.
- Mid-stream reset: rst_p high for 1 cycle while occ=2 and inflight=2. Required: all outputs return to reset values, and the next request address is RESET_PC.
